// File: rtl/hex_word_if.sv
// Word bus of the hex line receiver: serial input plus decoded word/status.
// master = receiver side, slave = host/consumer side.
interface hex_word_if;
  logic        RxD;
  logic [31:0] value;
  logic        value_valid;
  logic [3:0]  digit_cnt;
  logic        char_err;
  logic        frame_err;
  logic        busy;

  modport master (
    input  RxD,
    output value, value_valid, digit_cnt,
    output char_err, frame_err, busy
  );

  modport slave (
    output RxD,
    input  value, value_valid, digit_cnt,
    input  char_err, frame_err, busy
  );
endinterface

// File: rtl/hex_word_rx.sv
// 8N1 UART receiver feeding an ASCII hex line parser.
// Up to 8 hex digits per LF-terminated line become a 32-bit word.
module hex_word_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       RST,
  hex_word_if.master bus
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW = $clog2(BIT_TICKS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_rdy;
  logic          ferr;

  logic [31:0] acc;
  logic [3:0]  digits;
  logic        drop;
  logic [31:0] value_q;
  logic        vv_q;
  logic        cerr_q;
  logic        is_hex;
  logic [3:0]  nib;

  assign rxd_s = sync[1];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) sync <= 2'b11;
    else      sync <= {sync[0], bus.RxD};
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      byte_rdy <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      ferr     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            if (!rxd_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rxd_s;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxd_s) byte_rdy <= 1'b1;
            else       ferr     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Letters a-f/A-F share low nibbles 1..6, so +9 yields 10..15.
  always_comb begin
    is_hex = 1'b0;
    nib    = shift[3:0];
    unique case (1'b1)
      (shift >= 8'h30 && shift <= 8'h39): is_hex = 1'b1;
      (shift >= 8'h41 && shift <= 8'h46),
      (shift >= 8'h61 && shift <= 8'h66): begin
        is_hex = 1'b1;
        nib    = shift[3:0] + 4'd9;
      end
      default: is_hex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      acc     <= '0;
      digits  <= '0;
      drop    <= 1'b0;
      value_q <= '0;
      vv_q    <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      vv_q   <= 1'b0;
      cerr_q <= 1'b0;
      if (ferr) begin
        drop <= 1'b1;
      end else if (byte_rdy) begin
        if (is_hex) begin
          if (!drop) begin
            if (digits == 4'd8) begin
              cerr_q <= 1'b1;
              drop   <= 1'b1;
            end else begin
              acc    <= {acc[27:0], nib};
              digits <= digits + 1'b1;
            end
          end
        end else if (shift == 8'h0D) begin
          drop <= drop;
        end else if (shift == 8'h0A) begin
          if (!drop && digits != 4'd0) begin
            value_q <= acc;
            vv_q    <= 1'b1;
          end
          acc    <= '0;
          digits <= '0;
          drop   <= 1'b0;
        end else begin
          cerr_q <= 1'b1;
          drop   <= 1'b1;
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.digit_cnt   = digits;
  assign bus.char_err    = cerr_q;
  assign bus.frame_err   = ferr;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_hex_word_rx.sv
// Bench for hex_word_rx: directed and random hex lines over a fast UART.
// A line-level reference model predicts word, digit count and pulses.
module tb_hex_word_rx;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_word_if bus ();

  hex_word_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (62_500)
  ) dut (
    .clk(clk),
    .RST(rst_n),
    .bus(bus)
  );

  int vec = 0;
  int bad = 0;
  int n_vv = 0;
  int n_ce = 0;
  int n_fe = 0;
  logic [31:0] m_value = '0;
  logic [7:0]  q[$];
  int          badi;

  always @(negedge clk) begin
    if (bus.value_valid) n_vv++;
    if (bus.char_err)    n_ce++;
    if (bus.frame_err)   n_fe++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    bus.RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit badstop);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
    drive_bit(!badstop, BIT);
    if (badstop) drive_bit(1'b1, 3 * BIT);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic run_line(input string tag, input int gapmax);
    int ce = 0;
    int fe = 0;
    int vv = 0;
    int dig = 0;
    bit dr = 0;
    int h;
    logic [31:0] v = '0;
    int v0 = n_vv;
    int c0 = n_ce;
    int f0 = n_fe;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], i == badi);
      h = hexval(q[i]);
      if (i == badi) begin
        fe++;
        dr = 1;
      end else if (q[i] == 8'h0D) begin
        dr = dr;
      end else if (q[i] == 8'h0A) begin
        if (!dr && dig > 0) begin
          m_value = v;
          vv++;
        end
        dig = 0;
        dr = 0;
        v = '0;
      end else if (h >= 0) begin
        if (!dr) begin
          if (dig == 8) begin
            ce++;
            dr = 1;
          end else begin
            v = v * 16 + h;
            dig++;
          end
        end
      end else begin
        ce++;
        dr = 1;
      end
      chk({tag, " digit_cnt"}, 32'(bus.digit_cnt), dig);
      repeat ($urandom_range(gapmax, 0)) @(negedge clk);
    end
    chk({tag, " valid pulses"}, n_vv - v0, vv);
    chk({tag, " char_err"}, n_ce - c0, ce);
    chk({tag, " frame_err"}, n_fe - f0, fe);
    chk({tag, " value"}, bus.value, m_value);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    q.delete();
    badi = -1;
  endtask

  task automatic rand_line();
    int nd;
    int d;
    logic [7:0] c;
    string junk;
    junk = "gz!-_ .x";
    nd = $urandom_range(10, 0);
    for (int i = 0; i < nd; i++) begin
      d = $urandom_range(15, 0);
      if (d < 10) c = 8'(48 + d);
      else if ($urandom_range(1, 0) == 1) c = 8'(55 + d);
      else c = 8'(87 + d);
      q.push_back(c);
    end
    if ($urandom_range(5, 0) == 0)
      q.insert($urandom_range(q.size(), 0),
               junk[$urandom_range(7, 0)]);
    if ($urandom_range(7, 0) == 0) q.push_back(8'h0D);
    q.push_back(8'h0A);
    if ($urandom_range(7, 0) == 0 && q.size() > 1)
      badi = $urandom_range(q.size() - 2, 0);
  endtask

  initial begin
    int c0;
    int f0;
    int v0;
    logic [7:0] b3;
    badi = -1;
    bus.RxD = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst value", bus.value, 0);
    chk("rst valid", 32'(bus.value_valid), 0);
    chk("rst digits", 32'(bus.digit_cnt), 0);
    chk("rst char_err", 32'(bus.char_err), 0);
    chk("rst frame_err", 32'(bus.frame_err), 0);
    chk("rst busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    push_str("0000abcd\n");
    run_line("abcd", 0);
    chk("abcd const", bus.value, 32'h0000ABCD);

    push_str("DEADBEEF\r\n");
    run_line("deadbeef", 0);
    chk("deadbeef const", bus.value, 32'hDEADBEEF);

    push_str("12\n");
    run_line("12", 3);
    chk("12 const", bus.value, 32'h12);
    push_str("\n");
    run_line("empty", 0);
    chk("empty const", bus.value, 32'h12);

    push_str("123456789\n");
    run_line("nine", 0);
    chk("nine const", bus.value, 32'h12);

    push_str("12g4\n");
    run_line("bad char", 0);
    push_str("00000001\n");
    run_line("one", 0);
    chk("one const", bus.value, 32'h1);

    push_str("12A4\n");
    badi = 2;
    run_line("stop low", 0);
    chk("stop low const", bus.value, 32'h1);

    c0 = n_ce;
    f0 = n_fe;
    v0 = n_vv;
    drive_bit(1'b0, BIT / 4);
    drive_bit(1'b1, 3 * BIT);
    chk("glitch busy", 32'(bus.busy), 0);
    chk("glitch pulses", (n_ce - c0) + (n_fe - f0) + (n_vv - v0), 0);
    chk("glitch digits", 32'(bus.digit_cnt), 0);

    push_str("12");
    run_line("partial", 0);
    b3 = 8'h33;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(b3[i], BIT);
    drive_bit(b3[4], BIT / 2);
    rst_n = 1'b0;
    m_value = '0;
    @(negedge clk);
    chk("midrst value", bus.value, 0);
    chk("midrst digits", 32'(bus.digit_cnt), 0);
    chk("midrst busy", 32'(bus.busy), 0);
    chk("midrst pulses", {29'd0, bus.value_valid,
                          bus.char_err, bus.frame_err}, 0);
    repeat (BIT / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(b3[i], BIT);
    drive_bit(1'b1, 2 * BIT);
    rst_n = 1'b1;
    drive_bit(1'b1, 2 * BIT);
    push_str("00C0FFEE\n");
    run_line("after rst", 0);
    chk("after rst const", bus.value, 32'h00C0FFEE);

    for (int n = 0; n < 30; n++) begin
      rand_line();
      run_line("random", 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
